// File: rtl/mips_pkg.sv
// Shared constants, FSM state type and request payload for the shared-memory arbiter.
package mips_pkg;

  localparam int unsigned DEPTH     = 1024;
  localparam int unsigned AGE_LIMIT = 3;

  localparam int unsigned NPORT = 3;
  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned AGE_W = 2;

  // Requester indices into grant/request vectors
  localparam int unsigned LD = 0;
  localparam int unsigned DM = 1;
  localparam int unsigned IF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_arb_sel.sv
// Fixed-priority winner select with a fetch-starvation override.
module mem_arb_sel
  import mips_pkg::NPORT, mips_pkg::AGE_W, mips_pkg::LD, mips_pkg::DM, mips_pkg::IF;
#(
  parameter int unsigned AGE_LIMIT = mips_pkg::AGE_LIMIT
) (
  input  logic [NPORT-1:0] req,
  input  logic [AGE_W-1:0] age,
  output logic [NPORT-1:0] win
);

  // ld > aged fetch > dm > fetch
  always_comb begin
    win = '0;
    if (req[LD]) begin
      win[LD] = 1'b1;
    end else if (req[IF] && (age == AGE_W'(AGE_LIMIT))) begin
      win[IF] = 1'b1;
    end else if (req[DM]) begin
      win[DM] = 1'b1;
    end else if (req[IF]) begin
      win[IF] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Three-port arbiter (loader, data, fetch) in front of a single-port SRAM with 1-cycle read latency.
module mem_arbiter
  import mips_pkg::state_t, mips_pkg::IDLE, mips_pkg::ACCESS, mips_pkg::RESP,
         mips_pkg::req_t, mips_pkg::NPORT, mips_pkg::AGE_W, mips_pkg::AW, mips_pkg::DW,
         mips_pkg::LD, mips_pkg::DM, mips_pkg::IF;
#(
  parameter int unsigned DEPTH     = mips_pkg::DEPTH,
  parameter int unsigned AGE_LIMIT = mips_pkg::AGE_LIMIT
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          halted,
  input  logic          ld_req,
  input  logic [DW-1:0] ld_addr,
  input  logic          ld_we,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata,
  input  logic          dm_req,
  input  logic [DW-1:0] dm_addr,
  input  logic          dm_we,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  input  logic          if_req,
  input  logic [DW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          addr_err
);

  state_t           state_q, state_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic [NPORT-1:0] elig, win;
  logic [NPORT-1:0] gnt_q, gnt_d, rvalid_q, rvalid_d;
  logic             oor_q, oor_d;
  logic             mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic             addr_err_q, addr_err_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
  req_t             pick;
  logic             pick_oor;

  always_comb begin
    elig     = '0;
    elig[LD] = ld_req & halted;
    elig[DM] = dm_req;
    elig[IF] = if_req;
  end

  mem_arb_sel #(.AGE_LIMIT(AGE_LIMIT)) u_sel (
    .req (elig),
    .age (age_q),
    .win (win)
  );

  // Winner payload mux; fetch is read-only
  always_comb begin
    pick.addr  = if_addr;
    pick.we    = 1'b0;
    pick.wdata = '0;
    if (win[LD]) begin
      pick.addr  = ld_addr;
      pick.we    = ld_we;
      pick.wdata = ld_wdata;
    end else if (win[DM]) begin
      pick.addr  = dm_addr;
      pick.we    = dm_we;
      pick.wdata = dm_wdata;
    end
  end

  assign pick_oor = (pick.addr >= DW'(DEPTH));

  always_comb begin
    state_d     = state_q;
    age_d       = age_q;
    oor_d       = oor_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    addr_err_d  = 1'b0;
    if (!if_req) begin
      age_d = '0;
    end
    case (state_q)
      IDLE: begin
        if (|win) begin
          state_d     = ACCESS;
          gnt_d       = win;
          oor_d       = pick_oor;
          mem_en_d    = ~pick_oor;
          mem_we_d    = pick.we;
          mem_addr_d  = pick.addr[AW-1:0];
          mem_wdata_d = pick.wdata;
          addr_err_d  = pick_oor;
          if (win[IF]) begin
            age_d = '0;
          end else if (if_req && (age_q != AGE_W'(AGE_LIMIT))) begin
            age_d = age_q + AGE_W'(1);
          end
        end
      end
      // mem_we_q still holds the latched write flag during ACCESS
      ACCESS: begin
        if (mem_we_q) begin
          state_d = IDLE;
        end else begin
          state_d  = RESP;
          rvalid_d = gnt_q;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= IDLE;
      age_q       <= '0;
      oor_q       <= 1'b0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      age_q       <= age_d;
      oor_q       <= oor_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign ld_gnt    = gnt_q[LD];
  assign dm_gnt    = gnt_q[DM];
  assign if_gnt    = gnt_q[IF];
  assign ld_rvalid = rvalid_q[LD];
  assign dm_rvalid = rvalid_q[DM];
  assign if_rvalid = rvalid_q[IF];

  // SRAM data arrives during RESP, so read data is a gated pass-through
  assign ld_rdata = (rvalid_q[LD] && !oor_q) ? mem_rdata : '0;
  assign dm_rdata = (rvalid_q[DM] && !oor_q) ? mem_rdata : '0;
  assign if_rdata = (rvalid_q[IF] && !oor_q) ? mem_rdata : '0;

  // Keep the SRAM from committing an access on the edge that resets the arbiter
  assign mem_en    = mem_en_q & ~rst;
  assign mem_we    = mem_we_q & ~rst;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected grant/read events, a monitor checks them.
module tb_mem_arbiter;
  import mips_pkg::*;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        halted;
  logic        req_v   [NPORT];
  logic [31:0] addr_v  [NPORT];
  logic        we_v    [NPORT];
  logic [31:0] wdata_v [NPORT];

  logic        ld_gnt, ld_rvalid, dm_gnt, dm_rvalid, if_gnt, if_rvalid;
  logic [31:0] ld_rdata, dm_rdata, if_rdata;
  logic        mem_en, mem_we, addr_err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] sram [DEPTH];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  bit          mon_on = 1'b0;

  typedef struct {
    bit          rv;
    int          port;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  wire [NPORT-1:0] gnt_vec = {if_gnt, dm_gnt, ld_gnt};
  wire [NPORT-1:0] rv_vec  = {if_rvalid, dm_rvalid, ld_rvalid};
  logic [31:0]     rdata_vec [NPORT];
  assign rdata_vec[LD] = ld_rdata;
  assign rdata_vec[DM] = dm_rdata;
  assign rdata_vec[IF] = if_rdata;

  mem_arbiter dut (
    .clk1      (clk1),
    .rst       (rst),
    .halted    (halted),
    .ld_req    (req_v[LD]),
    .ld_addr   (addr_v[LD]),
    .ld_we     (we_v[LD]),
    .ld_wdata  (wdata_v[LD]),
    .ld_gnt    (ld_gnt),
    .ld_rvalid (ld_rvalid),
    .ld_rdata  (ld_rdata),
    .dm_req    (req_v[DM]),
    .dm_addr   (addr_v[DM]),
    .dm_we     (we_v[DM]),
    .dm_wdata  (wdata_v[DM]),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .if_req    (req_v[IF]),
    .if_addr   (addr_v[IF]),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .addr_err  (addr_err)
  );

  always #5 clk1 = ~clk1;
  always @(posedge clk1) cyc <= cyc + 1;

  // SRAM model: one-cycle registered read
  always @(posedge clk1) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit rv, input int port, input logic [31:0] data, input int c);
    exp_t e;
    e.rv = rv; e.port = port; e.data = data; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic drive(input int port, input logic [31:0] a, input logic w, input logic [31:0] d);
    addr_v[port]  = a;
    we_v[port]    = w;
    wdata_v[port] = d;
    req_v[port]   = 1'b1;
  endtask

  // Hold request until granted, then drop it for the following cycle
  task automatic wait_gnt(input int port);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk1); #1;
      if (gnt_vec[port]) begin
        req_v[port] = 1'b0;
        return;
      end
    end
    check("gnt_timeout", 32'(port), 32'hFFFF_FFFF);
    req_v[port] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0) return;
      @(posedge clk1); #1;
    end
    check("drain_timeout", 32'(sb.size()), 0);
    sb.delete();
  endtask

  task automatic expect_event(input bit rv, input logic [NPORT-1:0] vec);
    exp_t  e;
    string k;
    if (rv) k = "rvalid"; else k = "gnt";
    if (sb.size() == 0) begin
      check({"unexpected_", k}, 32'(vec), 0);
      return;
    end
    e = sb.pop_front();
    check({k, "_kind"}, 32'(rv), 32'(e.rv));
    check({k, "_port"}, 32'(vec), 32'(1) << e.port);
    check({k, "_cycle"}, 32'(cyc), 32'(e.cyc));
    if (rv) check("rvalid_data", rdata_vec[e.port], e.data);
  endtask

  logic [31:0] leak;
  always @(negedge clk1) begin
    if (mon_on) begin
      leak = '0;
      for (int p = 0; p < int'(NPORT); p++) if (!rv_vec[p]) leak |= rdata_vec[p];
      check("rdata_gated", leak, 0);
      check("onehot_gnt", 32'($onehot0(gnt_vec)), 1);
      check("onehot_rvalid", 32'($onehot0(rv_vec)), 1);
      if (|gnt_vec) expect_event(1'b0, gnt_vec);
      if (|rv_vec)  expect_event(1'b1, rv_vec);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1'b1;
    halted = 1'b0;
    for (int p = 0; p < int'(NPORT); p++) begin
      req_v[p] = 1'b0; addr_v[p] = '0; we_v[p] = 1'b0; wdata_v[p] = '0;
    end
    for (int unsigned i = 0; i < DEPTH; i++) sram[i] = '0;
    sram[3] = 32'h0000_ABCD;
    sram[5] = 32'h0000_1234;
    sram[7] = 32'h7777_0007;
    for (int k = 0; k < 4; k++) sram[20 + k] = 32'h2000_0014 + 32'(k);

    // Reset state
    repeat (3) @(posedge clk1);
    #1;
    check("rst_gnt", 32'(gnt_vec), 0);
    check("rst_rvalid", 32'(rv_vec), 0);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_addr_err", 32'(addr_err), 0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    mon_on = 1'b1;

    // Single fetch read of word 5
    c = cyc;
    push(1'b0, IF, '0, c + 1);
    push(1'b1, IF, 32'h0000_1234, c + 2);
    drive(IF, 32'd5, 1'b0, '0);
    wait_gnt(IF);
    drain();

    // Loader gated until halted
    drive(LD, 32'd10, 1'b1, 32'h0000_DEAD);
    repeat (4) begin
      @(posedge clk1); #1;
      check("ld_gated", 32'(ld_gnt), 0);
    end
    halted = 1'b1;
    c = cyc;
    push(1'b0, LD, '0, c + 1);
    wait_gnt(LD);
    drain();
    check("ld_write_w10", sram[10], 32'h0000_DEAD);

    // Loader read-back; halted drops mid-access
    c = cyc;
    push(1'b0, LD, '0, c + 1);
    push(1'b1, LD, 32'h0000_DEAD, c + 2);
    drive(LD, 32'd10, 1'b0, '0);
    wait_gnt(LD);
    halted = 1'b0;
    drain();

    // dm vs fetch contention: dm wins three times, aged fetch wins the fourth
    c = cyc;
    for (int k = 0; k < 3; k++) begin
      push(1'b0, DM, '0, c + 1 + 3 * k);
      push(1'b1, DM, 32'h2000_0014 + 32'(k), c + 2 + 3 * k);
    end
    push(1'b0, IF, '0, c + 10);
    push(1'b1, IF, 32'h7777_0007, c + 11);
    push(1'b0, DM, '0, c + 13);
    push(1'b1, DM, 32'h2000_0017, c + 14);
    drive(DM, 32'd20, 1'b0, '0);
    drive(IF, 32'd7, 1'b0, '0);
    fork
      begin
        wait_gnt(DM);
        for (int k = 1; k < 4; k++) begin
          repeat (2) @(posedge clk1);
          #1;
          drive(DM, 32'd20 + 32'(k), 1'b0, '0);
          wait_gnt(DM);
        end
      end
      begin
        wait_gnt(IF);
        check("age_after_fetch", 32'(dut.age_q), 0);
      end
    join
    drain();

    // Out-of-range dm read
    c = cyc;
    push(1'b0, DM, '0, c + 1);
    push(1'b1, DM, '0, c + 2);
    drive(DM, 32'd1024, 1'b0, '0);
    wait_gnt(DM);
    check("oor_mem_en", 32'(mem_en), 0);
    check("oor_addr_err", 32'(addr_err), 1);
    @(posedge clk1); #1;
    check("oor_err_once", 32'(addr_err), 0);
    check("oor_mem_en_resp", 32'(mem_en), 0);
    drain();

    // Back-to-back dm writes to 0..3
    c = cyc;
    for (int i = 0; i < 4; i++) push(1'b0, DM, '0, c + 1 + 2 * i);
    for (int i = 0; i < 4; i++) begin
      drive(DM, 32'(i), 1'b1, 32'hA000_0000 + 32'(i));
      wait_gnt(DM);
      check("wr_mem_en", 32'(mem_en), 1);
      check("wr_mem_we", 32'(mem_we), 1);
      check("wr_mem_addr", 32'(mem_addr), 32'(i));
      check("wr_mem_wdata", mem_wdata, 32'hA000_0000 + 32'(i));
      if (i < 3) begin
        @(posedge clk1); #1;
      end
    end
    drain();
    for (int i = 0; i < 4; i++) check("wr_sram", sram[i], 32'hA000_0000 + 32'(i));

    // Reset during ACCESS of a fetch read
    c = cyc;
    push(1'b0, IF, '0, c + 1);
    drive(IF, 32'd3, 1'b0, '0);
    wait_gnt(IF);
    rst = 1'b1;
    @(posedge clk1); #1;
    check("mid_rst_gnt", 32'(gnt_vec), 0);
    check("mid_rst_rvalid", 32'(rv_vec), 0);
    check("mid_rst_rdata", ld_rdata | dm_rdata | if_rdata, 0);
    check("mid_rst_mem_en", 32'(mem_en), 0);
    check("mid_rst_mem_we", 32'(mem_we), 0);
    check("mid_rst_mem_addr", 32'(mem_addr), 0);
    check("mid_rst_mem_wdata", mem_wdata, 0);
    check("mid_rst_addr_err", 32'(addr_err), 0);
    check("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    repeat (3) @(posedge clk1);
    #1;
    drain();
    check("no_pending", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
